// File: rtl/handshake_ctrl.sv
// Switch/LED handshake controller: synchronises and debounces SW8 into ready, captures the
// switch word on each debounced rise, and latches the ALU result onto the LEDs on disp.
module handshake_ctrl #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              sw_ready_raw,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              disp,
    input  logic [DATA_W-1:0] disp_data,
    output logic              ready,
    output logic [DATA_W-1:0] in_data,
    output logic              capture_pulse,
    output logic [DATA_W-1:0] leds,
    output logic [1:0]        hs_state
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StHeld    = 2'b10,
        StRelease = 2'b11
    } hs_state_e;

    logic              rdy_meta_q, rdy_s_q;
    logic [DATA_W-1:0] dat_meta_q, dat_s_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    hs_state_e         state_q, state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              cap_q;
    logic [DATA_W-1:0] leds_q, leds_d;

    always_comb begin
        ready_d = ready_q;
        cnt_d   = cnt_q;
        if (rdy_s_q == ready_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            ready_d = rdy_s_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The FSM reacts to ready_d so the capture lands in the same edge that ready rises.
    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        unique case (state_q)
            StIdle: begin
                if (ready_d) begin
                    state_d   = StCapture;
                    in_data_d = dat_s_q;
                end
            end
            StCapture: state_d = StHeld;
            StHeld: begin
                if (!ready_d) state_d = StRelease;
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        leds_d = leds_q;
        if (disp) leds_d = disp_data;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            dat_meta_q <= '0;
            dat_s_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            state_q    <= StIdle;
            in_data_q  <= '0;
            cap_q      <= 1'b0;
            leds_q     <= '0;
        end else begin
            rdy_meta_q <= sw_ready_raw;
            rdy_s_q    <= rdy_meta_q;
            dat_meta_q <= sw_data;
            dat_s_q    <= dat_meta_q;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            in_data_q  <= in_data_d;
            cap_q      <= (state_d == StCapture);
            leds_q     <= leds_d;
        end
    end

    assign ready         = ready_q;
    assign in_data       = in_data_q;
    assign capture_pulse = cap_q;
    assign leds          = leds_q;
    assign hs_state      = state_q;

endmodule

// File: tb/tb_handshake_ctrl.sv
// Bench for handshake_ctrl: directed handshake scenarios followed by randomized traffic, all
// compared every cycle against a queue-based reference model.
module tb_handshake_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          nReset;
    logic          sw_ready_raw;
    logic [DW-1:0] sw_data;
    logic          disp;
    logic [DW-1:0] disp_data;
    logic          ready;
    logic [DW-1:0] in_data;
    logic          capture_pulse;
    logic [DW-1:0] leds;
    logic [1:0]    hs_state;

    handshake_ctrl #(
        .DATA_W          (DW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .nReset        (nReset),
        .sw_ready_raw  (sw_ready_raw),
        .sw_data       (sw_data),
        .disp          (disp),
        .disp_data     (disp_data),
        .ready         (ready),
        .in_data       (in_data),
        .capture_pulse (capture_pulse),
        .leds          (leds),
        .hs_state      (hs_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: raw samples age through a 3-deep queue, so the oldest entry is the
    // synchronised value the debouncer sees at this edge.
    bit            raw_h[$];
    logic [DW-1:0] dat_h[$];
    int            run;
    bit            m_ready;
    int            m_st;
    logic [DW-1:0] m_in;
    logic [DW-1:0] m_leds;
    bit            m_cap;

    function automatic void model_reset();
        raw_h = {};
        dat_h = {};
        raw_h.push_back(1'b0);
        raw_h.push_back(1'b0);
        dat_h.push_back('0);
        dat_h.push_back('0);
        run     = 0;
        m_ready = 1'b0;
        m_st    = 0;
        m_in    = '0;
        m_leds  = '0;
        m_cap   = 1'b0;
    endfunction

    function automatic void model_step();
        bit            s;
        logic [DW-1:0] ds;
        if (raw_h.size() == 3) void'(raw_h.pop_front());
        if (dat_h.size() == 3) void'(dat_h.pop_front());
        raw_h.push_back(sw_ready_raw);
        dat_h.push_back(sw_data);
        s  = raw_h[0];
        ds = dat_h[0];
        // ready follows the synchronised level only after DB consecutive disagreeing samples
        if (s != m_ready) begin
            run++;
            if (run == DB) begin
                m_ready = s;
                run     = 0;
            end
        end else begin
            run = 0;
        end
        case (m_st)
            0: if (m_ready) begin m_st = 1; m_in = ds; end
            1: m_st = 2;
            2: if (!m_ready) m_st = 3;
            default: m_st = 0;
        endcase
        m_cap = (m_st == 1);
        if (disp) m_leds = disp_data;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"}, 32'(ready), 32'(m_ready));
        check({tag, ".in_data"}, 32'(in_data), 32'(m_in));
        check({tag, ".cap"}, 32'(capture_pulse), 32'(m_cap));
        check({tag, ".leds"}, 32'(leds), 32'(m_leds));
        check({tag, ".state"}, 32'(hs_state), 32'(m_st));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (nReset) model_step();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    // Ticks until ready reaches lvl; returns edge count, or 21 when the bound expires.
    task automatic wait_ready(input string tag, input logic lvl, output int n);
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            tick(tag);
            if (ready === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    int n_edges;
    int hold_cnt;

    initial begin
        nReset       = 1'b0;
        sw_ready_raw = 1'b0;
        sw_data      = '0;
        disp         = 1'b0;
        disp_data    = '0;
        model_reset();
        #1;
        check_all("por");

        // Inputs toggling under reset must not disturb anything.
        for (int i = 0; i < 6; i++) begin
            sw_ready_raw = ~sw_ready_raw;
            sw_data      = DW'($urandom);
            disp         = 1'b1;
            disp_data    = DW'($urandom);
            tick("in_rst");
            check("in_rst.leds0", 32'(leds), 32'h0);
        end
        nReset       = 1'b1;
        sw_ready_raw = 1'b0;
        disp         = 1'b0;
        sw_data      = 8'hA5;
        repeat (3) tick("settle");

        // First capture
        sw_ready_raw = 1'b1;
        wait_ready("rise1", 1'b1, n_edges);
        check("rise1.lat", 32'(n_edges), 32'(2 + DB));
        check("rise1.data", 32'(in_data), 32'hA5);
        check("rise1.state", 32'(hs_state), 32'h1);
        check("rise1.pulse", 32'(capture_pulse), 32'h1);
        tick("held");
        check("held.state", 32'(hs_state), 32'h2);
        check("held.pulse", 32'(capture_pulse), 32'h0);

        // Glitch shorter than the debounce window, with new data waiting
        sw_data      = 8'h3C;
        sw_ready_raw = 1'b0;
        repeat (3) tick("glitch");
        sw_ready_raw = 1'b1;
        repeat (8) tick("glitch_rec");
        check("glitch.ready", 32'(ready), 32'h1);
        check("glitch.data", 32'(in_data), 32'hA5);

        // Genuine release
        sw_ready_raw = 1'b0;
        wait_ready("fall", 1'b0, n_edges);
        check("fall.lat", 32'(n_edges), 32'(2 + DB));
        check("fall.state", 32'(hs_state), 32'h3);
        tick("idle");
        check("idle.state", 32'(hs_state), 32'h0);
        check("idle.data", 32'(in_data), 32'hA5);

        // Second capture picks up the word changed while ready was high
        sw_ready_raw = 1'b1;
        wait_ready("rise2", 1'b1, n_edges);
        check("rise2.lat", 32'(n_edges), 32'(2 + DB));
        check("rise2.data", 32'(in_data), 32'h3C);

        // Display strobes, last value wins then holds
        disp      = 1'b1;
        disp_data = 8'h7F;
        tick("disp1");
        check("disp1.leds", 32'(leds), 32'h7F);
        disp_data = 8'h80;
        tick("disp2");
        check("disp2.leds", 32'(leds), 32'h80);
        disp      = 1'b0;
        disp_data = 8'h11;
        repeat (2) tick("disp_hold");
        check("disp_hold.leds", 32'(leds), 32'h80);

        // Reset two counts into a rise
        sw_ready_raw = 1'b0;
        repeat (10) tick("drain");
        sw_data      = 8'hC3;
        sw_ready_raw = 1'b1;
        repeat (4) tick("pre_rst");
        nReset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.leds0", 32'(leds), 32'h0);
        tick("rst_hold");
        nReset = 1'b1;
        wait_ready("rerise", 1'b1, n_edges);
        check("rerise.lat", 32'(n_edges), 32'(2 + DB));
        check("rerise.data", 32'(in_data), 32'hC3);
        check("rerise.state", 32'(hs_state), 32'h1);

        // Randomized traffic with occasional resets
        hold_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold_cnt == 0) begin
                sw_ready_raw = 1'($urandom_range(0, 1));
                hold_cnt     = int'($urandom_range(1, 9));
            end
            hold_cnt--;
            sw_data   = DW'($urandom);
            disp      = ($urandom_range(0, 2) == 0);
            disp_data = DW'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                nReset = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                tick("rnd_rst_hold");
                nReset = 1'b1;
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
